stack_arbiter: RTL and testbench

//  Shares the CPU's hardware operand stack (push/pop/tos strobes, registered d_out) between two requesters.

---
 rtl/stack_arb_pkg.sv | 22 ++
 rtl/stack_arb_grant.sv | 50 +++++
 rtl/stack_arbiter.sv | 155 +++++++++++++++
 tb/tb_stack_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// Shared types for the operand-stack arbiter: operation encodings and FSM states.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        OP_ILL  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_TOS  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_RESP  = 2'b10
    } state_e;

    // POP and TOS both return a value read from the stack.
    function automatic logic isRead(input op_e op);
        return (op == OP_POP) || (op == OP_TOS);
    endfunction

endpackage

// File: rtl/stack_arb_grant.sv
// Two-way grant selection for the stack arbiter.
// Macro STACK_ARB_RR_EN selects round-robin (pointer toggles on every accept);
// otherwise requester 0 has fixed priority.
module stack_arb_grant (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic       grant_o
);

`ifdef STACK_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    // Pointer names the requester that wins a tie; flips after each accepted request.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = ~ptr_q;
        end
    end

    // Pointer register, prefers requester 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // With both requesting the pointer decides; otherwise the lone requester wins.
    always_comb begin
        grant_o = valid_i[1];
        if (valid_i == 2'b11) begin
            grant_o = ptr_q;
        end
    end
`else
    logic unusedInputs;
    assign unusedInputs = ^{clk, rst_n, accept_i};

    // Fixed priority: requester 1 only wins when requester 0 is idle.
    always_comb begin
        grant_o = valid_i[1] & ~valid_i[0];
    end
`endif

endmodule

// File: rtl/stack_arbiter.sv
// Shares the hardware operand stack between the control unit (requester 0) and
// the debug/interrupt port (requester 1). One PUSH/POP/TOS transaction at a time,
// occupancy tracking, and error responses for overflow/underflow/illegal ops.
// Macro STACK_ARB_RR_EN enables round-robin arbitration (see stack_arb_grant).
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_op,
    input  logic [2*WIDTH-1:0] req_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               stk_push,
    output logic               stk_pop,
    output logic               stk_tos,
    output logic [WIDTH-1:0]   stk_din,
    input  logic [WIDTH-1:0]   stk_dout,
    output logic [DEPTH:0]     count,
    output logic               full,
    output logic               empty
);

    localparam int              CAP_INT = 2 ** DEPTH;
    localparam logic [DEPTH:0]  CAP     = CAP_INT[DEPTH:0];
    localparam logic [DEPTH:0]  ONE     = {{DEPTH{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               id_q, id_d;
    logic               err_q, err_d;
    logic [DEPTH:0]     count_q, count_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               first_q, first_d;

    logic               grant;
    logic               accept;
    op_e                gOp;
    logic [WIDTH-1:0]   gData;
    logic               gErr;

    assign accept = (state_q == S_IDLE) && (|req_valid);
    assign gOp    = op_e'(grant ? req_op[3:2] : req_op[1:0]);
    assign gData  = grant ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];

    assign count  = count_q;
    assign full   = (count_q == CAP);
    assign empty  = (count_q == '0);

    // A request is rejected up front so the stack is never touched when it would misbehave.
    assign gErr = (gOp == OP_ILL) || ((gOp == OP_PUSH) && full) || (isRead(gOp) && empty);

    stack_arb_grant u_grant (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (req_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Response outputs; read data comes straight from the stack in the first RESP
    // cycle and from the hold register afterwards.
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_valid & id_q;
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_data  = (rsp_valid && !err_q && isRead(op_q)) ? (first_q ? stk_dout : hold_q) : '0;

    // Next-state, strobe and handshake decode for the IDLE -> ISSUE -> RESP sequence.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        id_d      = id_q;
        err_d     = err_q;
        count_d   = count_q;
        hold_d    = hold_q;
        first_d   = 1'b0;
        req_ready = 2'b00;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_tos   = 1'b0;
        stk_din   = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    op_d    = gOp;
                    data_d  = gData;
                    id_d    = grant;
                    err_d   = gErr;
                    state_d = gErr ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                stk_din = data_q;
                case (op_q)
                    OP_PUSH: begin
                        stk_push = 1'b1;
                        count_d  = count_q + ONE;
                    end
                    OP_POP: begin
                        stk_pop = 1'b1;
                        count_d = count_q - ONE;
                    end
                    OP_TOS:  stk_tos = 1'b1;
                    default: ;
                endcase
                first_d = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (first_q) begin
                    hold_d = stk_dout;
                end
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, transaction latch, occupancy and response hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_ILL;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            hold_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: a behavioural stack drives stk_dout, a
// transaction-level model checks every cycle, and directed tests pin literal values.
module tb_stack_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        stk_push;
   logic        stk_pop;
   logic        stk_tos;
   logic [7:0]  stk_din;
   logic [7:0]  stk_dout;
   logic [7:0]  count;
   logic        full;
   logic        empty;

   int checks = 0;
   int errors = 0;

   stack_arbiter #(.WIDTH(8), .DEPTH(7)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_tos   (stk_tos),
      .stk_din   (stk_din),
      .stk_dout  (stk_dout),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural hardware stack with a registered d_out, reset with the arbiter.
   logic [7:0] mem [0:127];
   logic [7:0] sp;
   logic [6:0] topIdx;
   assign topIdx = 7'(sp - 8'd1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp       <= 8'd0;
         stk_dout <= 8'd0;
      end else if (stk_push) begin
         mem[sp[6:0]] <= stk_din;
         sp           <= sp + 8'd1;
      end else if (stk_pop) begin
         stk_dout <= mem[topIdx];
         sp       <= sp - 8'd1;
      end else if (stk_tos) begin
         stk_dout <= mem[topIdx];
      end
   end

   // Transaction-level reference: a queue holds the stack contents; each accepted
   // request becomes an expected strobe one cycle later and a response after that
   // (or a response one cycle later for a rejected request).
   logic [7:0] mq[$];
   bit         busy = 0;
   int         k = 0;
   bit         ptr = 0;
   logic [1:0] tOp;
   logic [7:0] tData;
   logic       tId;
   logic       tErr;
   logic [7:0] tRes;

   always @(negedge clk) begin
      logic [1:0] expReady;
      logic [2:0] expStrb;
      logic       expRv;
      logic       g;
      if (!rst_n) begin
         mq.delete();
         busy = 0;
         k    = 0;
         ptr  = 0;
         checkOutput("mdlRstReady", {30'd0, req_ready}, 32'd0);
         checkOutput("mdlRstRv", {31'd0, rsp_valid}, 32'd0);
         checkOutput("mdlRstStrb", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
         checkOutput("mdlRstCount", {24'd0, count}, 32'd0);
         checkOutput("mdlRstFlags", {30'd0, full, empty}, 32'd1);
      end else begin
         if (busy) begin
            k++;
            if (!tErr && k == 2) begin
               case (tOp)
                  2'b01: begin mq.push_back(tData); tRes = 8'd0; end
                  2'b10: tRes = mq.pop_back();
                  default: tRes = mq[$];
               endcase
            end
         end
         expReady = 2'b00;
         expStrb  = 3'b000;
         expRv    = 1'b0;
         g        = 1'b0;
         if (!busy) begin
            if (req_valid != 2'b00) begin
`ifdef STACK_ARB_RR_EN
               g = (req_valid == 2'b11) ? ptr : req_valid[1];
`else
               g = !req_valid[0];
`endif
               expReady = g ? 2'b10 : 2'b01;
            end
         end else begin
            if (!tErr && k == 1) begin
               expStrb = (tOp == 2'b01) ? 3'b100 : (tOp == 2'b10) ? 3'b010 : 3'b001;
            end
            if (tErr || k >= 2) begin
               expRv = 1'b1;
            end
         end
         checkOutput("mdlReady", {30'd0, req_ready}, {30'd0, expReady});
         checkOutput("mdlStrb", {29'd0, stk_push, stk_pop, stk_tos}, {29'd0, expStrb});
         if (expStrb != 3'b000) begin
            checkOutput("mdlDin", {24'd0, stk_din}, {24'd0, tData});
         end
         checkOutput("mdlRv", {31'd0, rsp_valid}, {31'd0, expRv});
         if (expRv) begin
            checkOutput("mdlRspId", {31'd0, rsp_id}, {31'd0, tId});
            checkOutput("mdlRspErr", {31'd0, rsp_err}, {31'd0, tErr});
            checkOutput("mdlRspData", {24'd0, rsp_data}, tErr ? 32'd0 : {24'd0, tRes});
         end
         checkOutput("mdlCount", {24'd0, count}, mq.size());
         checkOutput("mdlFull", {31'd0, full}, {31'd0, mq.size() == 128});
         checkOutput("mdlEmpty", {31'd0, empty}, {31'd0, mq.size() == 0});
         if (!busy && req_valid != 2'b00) begin
            tOp   = g ? req_op[3:2] : req_op[1:0];
            tData = g ? req_data[15:8] : req_data[7:0];
            tId   = g;
            tErr  = (tOp == 2'b00) || (tOp == 2'b01 && mq.size() == 128) ||
                    (tOp != 2'b01 && mq.size() == 0);
            tRes  = 8'd0;
            busy  = 1;
            k     = 0;
            ptr   = !ptr;
         end else if (busy && expRv && rsp_ready) begin
            busy = 0;
         end
      end
   end

   // Runs one transaction from requester r; called and returning just after a rising edge.
   task automatic applyStimulus(input int r, input logic [1:0] op, input logic [7:0] d, input int hold,
                                output logic [7:0] rdata, output logic rerr, output int lat,
                                output logic [2:0] strb1, output logic [7:0] din1);
      int cyc;
      rdata = 8'd0; rerr = 1'b0; lat = 0; strb1 = 3'd0; din1 = 8'd0;
      req_valid[r]        = 1'b1;
      req_op[2*r +: 2]    = op;
      req_data[8*r +: 8]  = d;
      rsp_ready           = (hold == 0);
      cyc = 0;
      @(negedge clk);
      while (!req_ready[r] && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!req_ready[r]) begin
         checkOutput("acceptTimeout", 32'd0, 32'd1);
         req_valid[r] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid[r] = 1'b0;
      @(negedge clk);
      lat   = 1;
      strb1 = {stk_push, stk_pop, stk_tos};
      din1  = stk_din;
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         checkOutput("rspTimeout", 32'd0, 32'd1);
         return;
      end
      rdata = rsp_data;
      rerr  = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput("holdRv", {31'd0, rsp_valid}, 32'd1);
         checkOutput("holdData", {24'd0, rsp_data}, {24'd0, rdata});
         checkOutput("holdErrId", {30'd0, rsp_err, rsp_id}, {30'd0, rerr, r[0]});
         checkOutput("holdReady", {30'd0, req_ready}, 32'd0);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   // Reset pulse of a couple of cycles, releasing just after a rising edge.
   task automatic pulseReset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [7:0] rd;
   logic       re;
   int         lt;
   logic [2:0] sb;
   logic [7:0] di;
   int         grants [4];
   int         nGrant;
   int         cyc;

   // Watchdog so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_op    = 4'd0;
      req_data  = 16'd0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstCount", {24'd0, count}, 32'd0);
      checkOutput("rstEmpty", {31'd0, empty}, 32'd1);
      checkOutput("rstRv", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: PUSH A5 from requester 0.
      applyStimulus(0, 2'b01, 8'hA5, 0, rd, re, lt, sb, di);
      checkOutput("t1Strb", {29'd0, sb}, 32'h4);
      checkOutput("t1Din", {24'd0, di}, 32'hA5);
      checkOutput("t1Lat", lt, 32'd2);
      checkOutput("t1Err", {31'd0, re}, 32'd0);
      checkOutput("t1Data", {24'd0, rd}, 32'd0);
      checkOutput("t1Count", {24'd0, count}, 32'd1);

      // Test 2: POP returns A5, then a second POP underflows.
      applyStimulus(0, 2'b10, 8'h00, 0, rd, re, lt, sb, di);
      checkOutput("t2Strb", {29'd0, sb}, 32'h2);
      checkOutput("t2Data", {24'd0, rd}, 32'hA5);
      checkOutput("t2Count", {24'd0, count}, 32'd0);
      checkOutput("t2Empty", {31'd0, empty}, 32'd1);
      applyStimulus(0, 2'b10, 8'h00, 0, rd, re, lt, sb, di);
      checkOutput("t2UnderErr", {31'd0, re}, 32'd1);
      checkOutput("t2UnderLat", lt, 32'd1);
      checkOutput("t2UnderStrb", {29'd0, sb}, 32'd0);

      // Illegal op from requester 1 is rejected.
      applyStimulus(1, 2'b00, 8'h3C, 0, rd, re, lt, sb, di);
      checkOutput("illErr", {31'd0, re}, 32'd1);
      checkOutput("illLat", lt, 32'd1);

      // Test 3: fill to capacity, overflow, then TOS.
      for (int i = 0; i < 128; i++) begin
         applyStimulus(0, 2'b01, 8'(i), 0, rd, re, lt, sb, di);
      end
      checkOutput("t3Full", {31'd0, full}, 32'd1);
      checkOutput("t3Count", {24'd0, count}, 32'd128);
      applyStimulus(0, 2'b01, 8'hFF, 0, rd, re, lt, sb, di);
      checkOutput("t3OverErr", {31'd0, re}, 32'd1);
      checkOutput("t3OverLat", lt, 32'd1);
      checkOutput("t3OverCount", {24'd0, count}, 32'd128);
      applyStimulus(0, 2'b11, 8'h00, 0, rd, re, lt, sb, di);
      checkOutput("t3TosData", {24'd0, rd}, 32'h7F);
      checkOutput("t3TosStrb", {29'd0, sb}, 32'h1);
      checkOutput("t3TosCount", {24'd0, count}, 32'd128);

      // Test 5: response held for 5 cycles, then IDLE right after the handshake.
      applyStimulus(0, 2'b11, 8'h00, 5, rd, re, lt, sb, di);
      checkOutput("t5Data", {24'd0, rd}, 32'h7F);
      req_valid[1] = 1'b1;
      req_op[3:2]  = 2'b11;
      @(negedge clk);
      checkOutput("t5IdleReady", {30'd0, req_ready}, 32'h2);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Test 4: both requesters valid every cycle.
      pulseReset();
      req_op    = 4'b1111;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      nGrant    = 0;
      cyc       = 0;
      while (nGrant < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (req_ready != 2'b00) begin
            grants[nGrant] = req_ready[1] ? 1 : 0;
            nGrant++;
         end
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t4GrantCount", nGrant, 32'd4);
`ifdef STACK_ARB_RR_EN
      checkOutput("t4Grant0", grants[0], 32'd0);
      checkOutput("t4Grant1", grants[1], 32'd1);
      checkOutput("t4Grant2", grants[2], 32'd0);
      checkOutput("t4Grant3", grants[3], 32'd1);
`else
      checkOutput("t4Grant0", grants[0], 32'd0);
      checkOutput("t4Grant1", grants[1], 32'd0);
      checkOutput("t4Grant2", grants[2], 32'd0);
      checkOutput("t4Grant3", grants[3], 32'd0);
`endif

      // Test 6: reset asserted during ISSUE of a PUSH.
      applyStimulus(0, 2'b01, 8'h11, 0, rd, re, lt, sb, di);
      checkOutput("t6PreCount", {24'd0, count}, 32'd1);
      req_valid[0] = 1'b1;
      req_op[1:0]  = 2'b01;
      req_data[7:0] = 8'h22;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = 2'b00;
      checkOutput("t6InIssue", {31'd0, stk_push}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t6Count", {24'd0, count}, 32'd0);
      checkOutput("t6Strb", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
      checkOutput("t6Rv", {31'd0, rsp_valid}, 32'd0);
      checkOutput("t6Empty", {31'd0, empty}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("t6NoRsp", {31'd0, rsp_valid}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
